// File: rtl/pc_unit.sv
// ============================================================================
// pc_unit -- fetch-stage program counter for the pipelined MIPS core
// ----------------------------------------------------------------------------
// Purpose:
//   Holds the current fetch PC and picks the next one from, in priority order:
//   exception entry, ERET return, stall (hold), live redirect, buffered
//   redirect, sequential +4. A redirect that arrives while the front end is
//   stalled is parked in a one-entry buffer and applied on the first advancing
//   edge, so a branch resolved during a stall is never lost.
//
// Optional feature:
//   `define PC_UNIT_STALL_CNT_EN  -> saturating 32-bit stall-cycle counter on
//   stall_cnt. Without it, stall_cnt is tied to zero and no counter register
//   exists.
//
// Ports:
//   clk             in   1      clock, all state updates on rising edge
//   reset           in   1      synchronous, active-high reset
//   en              in   1      1 = advance PC, 0 = stall (hold PC)
//   redirect_valid  in   1      branch/jump taken this cycle
//   redirect_pc     in   WIDTH  redirect target
//   exc_req         in   1      exception/interrupt entry request
//   eret_req        in   1      ERET return request
//   epc             in   WIDTH  ERET return address
//   out_pc          out  WIDTH  current fetch PC (registered)
//   pending         out  1      a buffered redirect is waiting (registered)
//   fetch_exc       out  1      out_pc misaligned or outside IMEM window
//   stall_cnt       out  32     stall-cycle counter (0 when feature is off)
// ============================================================================
module pc_unit #(
   parameter int               WIDTH      = 32,
   parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(32'h0000_3000),
   parameter logic [WIDTH-1:0] HANDLER_PC = WIDTH'(32'h0000_4180),
   parameter logic [WIDTH-1:0] IMEM_LO    = WIDTH'(32'h0000_3000),
   parameter logic [WIDTH-1:0] IMEM_HI    = WIDTH'(32'h0000_6FFC)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_pc,
   input  logic             exc_req,
   input  logic             eret_req,
   input  logic [WIDTH-1:0] epc,
   output logic [WIDTH-1:0] out_pc,
   output logic             pending,
   output logic             fetch_exc,
   output logic [31:0]      stall_cnt
);

   localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

   // RUN: no buffered redirect. PEND: r_pend_pc holds a redirect that
   // arrived during a stall and must be taken on the next advancing edge.
   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_PEND = 1'b1
   } pend_state_t;

   pend_state_t      r_state;
   pend_state_t      w_state_nxt;
   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] w_pc_nxt;
   logic [WIDTH-1:0] r_pend_pc;
   logic [WIDTH-1:0] w_pend_pc_nxt;

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         // A redirect still buffered at reset is simply dropped.
         r_state   <= ST_RUN;
         r_pc      <= RESET_PC;
         r_pend_pc <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_pc      <= w_pc_nxt;
         r_pend_pc <= w_pend_pc_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state / next-PC selection
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_nxt   = r_state;
      w_pc_nxt      = r_pc + PC_STEP;   // wraps modulo 2^WIDTH
      w_pend_pc_nxt = r_pend_pc;

      if (exc_req) begin
         // Exception entry wins over everything, stall included; it also
         // kills any buffered redirect since that path is now dead.
         w_pc_nxt    = HANDLER_PC;
         w_state_nxt = ST_RUN;
      end else if (eret_req) begin
         w_pc_nxt    = epc;
         w_state_nxt = ST_RUN;
      end else if (!en) begin
         w_pc_nxt = r_pc;
         if (redirect_valid) begin
            // Newest redirect replaces any older buffered one.
            w_pend_pc_nxt = redirect_pc;
            w_state_nxt   = ST_PEND;
         end
      end else if (redirect_valid) begin
         // A live redirect is younger than a buffered one, so it wins.
         w_pc_nxt    = redirect_pc;
         w_state_nxt = ST_RUN;
      end else if (r_state == ST_PEND) begin
         w_pc_nxt    = r_pend_pc;
         w_state_nxt = ST_RUN;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   always_comb begin
      out_pc    = r_pc;
      pending   = (r_state == ST_PEND);
      // The unit never acts on this itself; exception logic answers with
      // exc_req. Unsigned compares against the legal IMEM window.
      fetch_exc = (r_pc[1:0] != 2'b00) | (r_pc < IMEM_LO) | (r_pc > IMEM_HI);
   end

   // -------------------------------------------------------------------------
   // Optional stall-cycle counter
   // -------------------------------------------------------------------------
`ifdef PC_UNIT_STALL_CNT_EN
   logic [31:0] r_stall_cnt;
   logic        w_stall;

   // Only true stalls count; an exception or ERET edge moves the PC even
   // with en low, so it is not a lost fetch cycle.
   assign w_stall = ~en & ~exc_req & ~eret_req;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`else
   assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a behavioural reference model tracks the
// expected PC / pending / counter state and is compared with the DUT on every
// falling edge, while hand-computed literal checks pin the model itself.
module tb_pc_unit;

`ifdef PC_UNIT_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, en, redirect_valid, exc_req, eret_req;
  logic [31:0] redirect_pc, epc;
  logic [31:0] out_pc;
  logic        pending, fetch_exc;
  logic [31:0] stall_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  pc_unit dut (
    .clk(clk), .reset(reset), .en(en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
    .out_pc(out_pc), .pending(pending), .fetch_exc(fetch_exc),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_pc, m_ppc, m_cnt;
  bit          m_pend;
  bit          m_ok = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_pc = 32'h3000; m_pend = 0; m_ppc = 0; m_cnt = 0; m_ok = 1;
    end else begin
      if (!en && !exc_req && !eret_req && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (exc_req)                  begin m_pc = 32'h4180;     m_pend = 0; end
      else if (eret_req)            begin m_pc = epc;          m_pend = 0; end
      else if (!en) begin
        if (redirect_valid)         begin m_ppc = redirect_pc; m_pend = 1; end
      end
      else if (redirect_valid)      begin m_pc = redirect_pc;  m_pend = 0; end
      else if (m_pend)              begin m_pc = m_ppc;        m_pend = 0; end
      else                          m_pc = m_pc + 32'd4;
    end
  end

  function automatic bit exp_fexc(logic [31:0] pc);
    return (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6FFC);
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (m_ok) begin
      chk("model out_pc",    out_pc,            m_pc);
      chk("model pending",   32'(pending),      32'(m_pend));
      chk("model fetch_exc", 32'(fetch_exc),    32'(exp_fexc(m_pc)));
      chk("model stall_cnt", stall_cnt,         CNT_EN ? m_cnt : 32'h0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    reset = 0; en = 1; redirect_valid = 0; redirect_pc = 0;
    exc_req = 0; eret_req = 0; epc = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle(); reset = 1; step(); reset = 0;
  endtask

  initial begin
    idle(); reset = 1;
    step(); step(); reset = 0;
    chk("reset pc",    out_pc,          32'h3000);
    chk("reset pend",  32'(pending),    32'd0);
    chk("reset fexc",  32'(fetch_exc),  32'd0);
    chk("reset cnt",   stall_cnt,       32'd0);

    // sequential fetch
    step(); chk("seq 1", out_pc, 32'h3004);
    step(); chk("seq 2", out_pc, 32'h3008);
    step(); chk("seq 3", out_pc, 32'h300C);
    chk("seq fexc", 32'(fetch_exc), 32'd0);
    step(); chk("seq 4", out_pc, 32'h3010);

    // redirect buffered during a stall
    en = 0; redirect_valid = 1; redirect_pc = 32'h3400;
    step(); chk("stall hold 1", out_pc, 32'h3010); chk("stall pend 1", 32'(pending), 32'd1);
    redirect_valid = 0; redirect_pc = 0;
    step(); chk("stall hold 2", out_pc, 32'h3010); chk("stall pend 2", 32'(pending), 32'd1);
    en = 1;
    step(); chk("pend apply", out_pc, 32'h3400); chk("pend clr", 32'(pending), 32'd0);
    step(); chk("after pend", out_pc, 32'h3404);

    // live redirect beats a stale pending one
    en = 0; redirect_valid = 1; redirect_pc = 32'h3400;
    step(); chk("pend again", 32'(pending), 32'd1);
    en = 1; redirect_pc = 32'h3800;
    step(); chk("live wins", out_pc, 32'h3800); chk("live clr", 32'(pending), 32'd0);

    // exception beats eret, stall and redirect
    en = 0; exc_req = 1; eret_req = 1; redirect_valid = 1; redirect_pc = 32'h3400;
    step(); chk("exc entry", out_pc, 32'h4180); chk("exc pend", 32'(pending), 32'd0);
    idle(); eret_req = 1; epc = 32'h3024;
    step(); chk("eret", out_pc, 32'h3024);

    // fetch-address exception boundaries
    idle(); redirect_valid = 1; redirect_pc = 32'h3002;
    step(); chk("misalign pc", out_pc, 32'h3002); chk("misalign fexc", 32'(fetch_exc), 32'd1);
    redirect_pc = 32'h7000;
    step(); chk("above hi", 32'(fetch_exc), 32'd1);
    redirect_pc = 32'h6FFC;
    step(); chk("at hi", 32'(fetch_exc), 32'd0);
    redirect_pc = 32'h2FFC;
    step(); chk("below lo", 32'(fetch_exc), 32'd1);

    // +4 wraps at top of address space
    redirect_pc = 32'hFFFF_FFFC;
    step(); redirect_valid = 0;
    step(); chk("wrap pc", out_pc, 32'h0); chk("wrap fexc", 32'(fetch_exc), 32'd1);

    // reset drops a pending redirect
    en = 0; redirect_valid = 1; redirect_pc = 32'h3500;
    step(); chk("pre-reset pend", 32'(pending), 32'd1);
    do_reset(); chk("reset pend drop", 32'(pending), 32'd0);
    step(); chk("no stale target", out_pc, 32'h3004);

    // stall counter: 4 true stalls + 1 exception edge with en low
    do_reset();
    en = 0;
    step(); step();
    exc_req = 1; step(); exc_req = 0;
    step(); step();
    chk("stall cnt", stall_cnt, CNT_EN ? 32'd4 : 32'd0);
    do_reset(); chk("cnt reset", stall_cnt, 32'd0);

    idle(); step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
